register_writeback_unit: RTL and testbench
==========================================

# register_writeback_unit

Writer side of the general-purpose register file: collects completed results from the single-cycle ALU path and the multi-cycle load path, orders them, and drives the file's write port (`wr_data`, `rd`, `rd_write_signal`) with one write per cycle. Loads are buffered in a small FIFO and optionally sign/zero-extended. ALU results have fixed priority. An anti-starvation counter asks the pipeline for a bubble when loads wait too long.

## Interface
- `LD_DEPTH`, 2: load FIFO entries (power of two, ≥2).
- `STARVE_LIMIT`, 4: consecutive cycles in which the ALU beats a waiting load before `bubble_req_out` asserts.
- `clk_in`  in  1  clock; all state updates on the rising edge.
- `rst_n_in`  in  1  asynchronous, active-low reset.
- `alu_valid_in`  in  1  ALU result present this cycle; always accepted (no ready).
- `alu_rd_in`  in  5  ALU destination register.
- `alu_data_in`  in  64  ALU result.
- `ld_valid_in`  in  1  load result offered.
- `ld_ready_out`  out  1  FIFO not full; a transfer occurs when valid and ready are both high.
- `ld_rd_in`  in  5  load destination register.
- `ld_data_in`  in  64  raw load data, right-aligned.
- `ld_funct3_in`  in  3  RV64 load funct3 (LB/LH/LW/LD/LBU/LHU/LWU).
- `stall_signal_in`  in  1  pipeline stall; freezes the write port and FIFO pop.
- `wr_data_out`  out  64  register-file write data.
- `rd_out`  out  5  register-file write index.
- `rd_write_signal_out`  out  1  register-file write enable.
- `bubble_req_out`  out  1  request for a one-cycle ALU bubble.
- `err_out`  out  1  sticky: ALU result received while stalled (dropped).

## Operation
- Per-cycle arbitration when not stalled:
  - if `alu_valid_in` is high, the ALU result is registered to the outputs;
  - otherwise, if the FIFO is non-empty, the head is popped and registered;
  - otherwise `rd_write_signal_out` is 0.
- x0 suppression: an entry with rd = 0 is consumed, but `rd_write_signal_out` stays 0 and `wr_data_out` is 0.
- Ordering: issue is in order, so an accepted ALU result is younger than every buffered load.
  - When an ALU result with rd ≠ 0 is accepted, every FIFO entry with the same rd is marked killed.
  - A killed entry still pops in turn but writes nothing.
  - A load pushed in the same cycle is not killed.
- FIFO: push when `ld_valid_in & ld_ready_out`.
  - `ld_ready_out = (count != LD_DEPTH)`.
  - Simultaneous push and pop is allowed at any count. When full, the push is refused that cycle even if a pop occurs.
- Starvation counter:
  - increments each unstalled cycle in which the ALU wins while the FIFO is non-empty;
  - clears on any FIFO pop or when the FIFO is empty.
  - `bubble_req_out` is high while count ≥ `STARVE_LIMIT`. The pipeline must drop `alu_valid_in` within 2 cycles.
- Stall: outputs hold their values, with `rd_write_signal_out` forced to 0 so the register file sees no duplicate write.
  - FIFO pushes continue; pops stop; the counter holds.
  - `alu_valid_in` during a stall drops the result and sets `err_out`.
- Reset: all outputs 0, FIFO empty with kill bits cleared, counter 0, `err_out` 0. Assertion mid-operation discards all buffered loads immediately.

## Timing
- ALU result sampled at edge N appears on the write port after edge N; the register file captures it on the following falling edge. Latency 1.
- Load pushed at edge N pops at the earliest at edge N+1. Minimum latency 2, with no bypass.
- `ld_ready_out` and `bubble_req_out` are derived only from registered state, with no combinational path from inputs.
- `err_out` clears only on reset.

## Configuration
- `WB_LOAD_EXTEND_EN` defined: load data is extended per `ld_funct3_in` when popped.
  - LB/LH/LW sign-extend from bit 7/15/31.
  - LBU/LHU/LWU zero-extend.
  - LD passes through.
  - Undefined funct3 values (3'b111) pass through.
- Undefined: `ld_data_in` is written unmodified and `ld_funct3_in` is ignored. The load path must pre-extend.

## Test plan
- ALU only: alu rd=5, data 0x1234 at edge 0 -> after edge 0: `rd_out`=5, `wr_data_out`=0x1234, `rd_write_signal_out`=1; one cycle later `rd_write_signal_out`=0.
- Load with extension: LB rd=7, data 0x80, ALU idle -> write of 0xFFFFFFFFFFFFFF80 two edges after the push (macro defined); write of 0x80 (macro undefined).
- Collision and kill:
  - stimulus: load rd=9 buffered, then ALU rd=9 data 0xAA in the next cycle with `alu_valid_in` held;
  - required: ALU write 0xAA to x9; when the load pops, no write; x9 stays 0xAA.
- Full FIFO: `LD_DEPTH`=2, ALU valid every cycle, 3 loads offered -> `ld_ready_out` low after 2 pushes; with `STARVE_LIMIT`=4, `bubble_req_out` rises after 4 ALU wins; dropping ALU valid pops the head and clears the counter.
- x0 and stall:
  - ALU rd=0 -> no write.
  - `stall_signal_in` high with `alu_valid_in` high -> result dropped, `err_out`=1, outputs held, write enable 0.
- Reset mid-operation: 2 loads buffered, `rst_n_in` low between edges -> immediately FIFO empty, `ld_ready_out`=1, all outputs 0.

Source files
------------

// File: rtl/register_writeback_unit.sv
// register_writeback_unit
// Drives the register-file write port (one write per cycle) from two sources.
// Single-cycle ALU results always win arbitration. Multi-cycle load results
// wait in a small FIFO. A load whose destination is overwritten by a younger
// ALU result is killed: it still pops in order but writes nothing.
// An anti-starvation counter raises bubble_req_out when loads wait too long.
// Optional feature macro: WB_LOAD_EXTEND_EN. When it is defined, load data is
// sign/zero-extended per ld_funct3_in as it pops. Otherwise the data is
// written unmodified.
// Load handshake: a load transfers on a rising edge where ld_valid_in and
// ld_ready_out are both high. ld_ready_out depends only on registered state.
module register_writeback_unit #(
   parameter int LD_DEPTH     = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        alu_valid_in,
   input  logic [4:0]  alu_rd_in,
   input  logic [63:0] alu_data_in,
   input  logic        ld_valid_in,
   output logic        ld_ready_out,
   input  logic [4:0]  ld_rd_in,
   input  logic [63:0] ld_data_in,
   input  logic [2:0]  ld_funct3_in,
   input  logic        stall_signal_in,
   output logic [63:0] wr_data_out,
   output logic [4:0]  rd_out,
   output logic        rd_write_signal_out,
   output logic        bubble_req_out,
   output logic        err_out
);

   localparam int PW = (LD_DEPTH > 1) ? $clog2(LD_DEPTH) : 1;
   localparam int CW = $clog2(LD_DEPTH + 1);
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   logic [63:0]         fifo_data [LD_DEPTH];
   logic [4:0]          fifo_rd   [LD_DEPTH];
   logic [LD_DEPTH-1:0] fifo_kill;
   logic [PW-1:0]       wr_ptr;
   logic [PW-1:0]       rd_ptr;
   logic [CW-1:0]       count;
   logic [SW-1:0]       starve_cnt;

   logic        fifo_empty;
   logic        push;
   logic        pop;
   logic        alu_accept;
   logic [63:0] head_data;
   logic        head_writes;

`ifdef WB_LOAD_EXTEND_EN
   logic [2:0]  fifo_f3 [LD_DEPTH];

   // RV64 load extension: LB/LH/LW sign-extend, LBU/LHU/LWU zero-extend,
   // LD and the undefined encoding pass through.
   function automatic logic [63:0] load_extend(input logic [63:0] d, input logic [2:0] f3);
      logic [63:0] r;
      case (f3)
         3'b000:  r = {{56{d[7]}},  d[7:0]};
         3'b001:  r = {{48{d[15]}}, d[15:0]};
         3'b010:  r = {{32{d[31]}}, d[31:0]};
         3'b100:  r = {56'd0, d[7:0]};
         3'b101:  r = {48'd0, d[15:0]};
         3'b110:  r = {32'd0, d[31:0]};
         default: r = d;
      endcase
      return r;
   endfunction

   // Load width travels with the entry so extension happens at pop time.
   always_ff @(posedge clk_in) begin
      if (push) fifo_f3[wr_ptr] <= ld_funct3_in;
   end

   assign head_data = load_extend(fifo_data[rd_ptr], fifo_f3[rd_ptr]);
`else
   logic unused_funct3;
   assign unused_funct3 = ^ld_funct3_in;
   assign head_data     = fifo_data[rd_ptr];
`endif

   assign fifo_empty     = (count == '0);
   assign ld_ready_out   = (count != CW'(LD_DEPTH));
   assign bubble_req_out = (starve_cnt >= SW'(STARVE_LIMIT));
   assign push           = ld_valid_in & ld_ready_out;
   assign alu_accept     = alu_valid_in & ~stall_signal_in;
   assign pop            = ~stall_signal_in & ~alu_valid_in & ~fifo_empty;
   assign head_writes    = ~fifo_kill[rd_ptr] & (fifo_rd[rd_ptr] != 5'd0);

   // Payload storage; only the occupancy and kill state need a reset.
   always_ff @(posedge clk_in) begin
      if (push) begin
         fifo_data[wr_ptr] <= ld_data_in;
         fifo_rd[wr_ptr]   <= ld_rd_in;
      end
   end

   // FIFO pointers, occupancy and kill bits. A push this cycle clears its own
   // kill bit, so a load arriving alongside the ALU result is never killed.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         fifo_kill <= '0;
      end else begin
         for (int i = 0; i < LD_DEPTH; i++) begin
            if (alu_accept && (alu_rd_in != 5'd0) && (fifo_rd[i] == alu_rd_in))
               fifo_kill[i] <= 1'b1;
         end
         if (push) begin
            fifo_kill[wr_ptr] <= 1'b0;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(push) - CW'(pop);
      end
   end

   // Starvation counter: counts ALU wins over a waiting load, saturating.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         starve_cnt <= '0;
      end else if (!stall_signal_in) begin
         if (alu_valid_in && !fifo_empty) begin
            if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
         end else begin
            starve_cnt <= '0;
         end
      end else if (fifo_empty) begin
         starve_cnt <= '0;
      end
   end

   // Write port: ALU first, then FIFO head; stall holds data with enable low.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         wr_data_out         <= '0;
         rd_out              <= '0;
         rd_write_signal_out <= 1'b0;
      end else if (stall_signal_in) begin
         rd_write_signal_out <= 1'b0;
      end else if (alu_valid_in) begin
         rd_out              <= alu_rd_in;
         wr_data_out         <= (alu_rd_in != 5'd0) ? alu_data_in : 64'd0;
         rd_write_signal_out <= (alu_rd_in != 5'd0);
      end else if (!fifo_empty) begin
         rd_out              <= head_writes ? fifo_rd[rd_ptr] : 5'd0;
         wr_data_out         <= head_writes ? head_data : 64'd0;
         rd_write_signal_out <= head_writes;
      end else begin
         rd_write_signal_out <= 1'b0;
      end
   end

   // Sticky error: an ALU result arrived while stalled and was dropped.
   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) err_out <= 1'b0;
      else if (stall_signal_in && alu_valid_in) err_out <= 1'b1;
   end

endmodule

// File: tb/tb_register_writeback_unit.sv
// tb_register_writeback_unit
// Directed scenarios followed by random traffic. A queue-based reference model
// predicts each register-file write; a monitor compares actual writes.
module tb_register_writeback_unit;

   localparam int LD_DEPTH     = 2;
   localparam int STARVE_LIMIT = 4;

   logic        clk_in = 1'b0;
   logic        rst_n_in = 1'b1;
   logic        alu_valid_in = 1'b0;
   logic [4:0]  alu_rd_in = '0;
   logic [63:0] alu_data_in = '0;
   logic        ld_valid_in = 1'b0;
   logic        ld_ready_out;
   logic [4:0]  ld_rd_in = '0;
   logic [63:0] ld_data_in = '0;
   logic [2:0]  ld_funct3_in = '0;
   logic        stall_signal_in = 1'b0;
   logic [63:0] wr_data_out;
   logic [4:0]  rd_out;
   logic        rd_write_signal_out;
   logic        bubble_req_out;
   logic        err_out;

   register_writeback_unit #(.LD_DEPTH(LD_DEPTH), .STARVE_LIMIT(STARVE_LIMIT)) dut (
      .clk_in(clk_in), .rst_n_in(rst_n_in),
      .alu_valid_in(alu_valid_in), .alu_rd_in(alu_rd_in), .alu_data_in(alu_data_in),
      .ld_valid_in(ld_valid_in), .ld_ready_out(ld_ready_out), .ld_rd_in(ld_rd_in),
      .ld_data_in(ld_data_in), .ld_funct3_in(ld_funct3_in),
      .stall_signal_in(stall_signal_in), .wr_data_out(wr_data_out), .rd_out(rd_out),
      .rd_write_signal_out(rd_write_signal_out), .bubble_req_out(bubble_req_out),
      .err_out(err_out)
   );

   // ---------------- clock ----------------
   always #5 clk_in = ~clk_in;

   // ---------------- reference model state ----------------
   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
      logic [2:0]  f3;
      bit          killed;
   } ld_t;

   ld_t         mq[$];
   int          m_starve = 0;
   bit          m_err = 1'b0;
   logic [63:0] m_rf [32];
   logic [63:0] d_rf [32];
   logic [68:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;

   function automatic logic [63:0] ld_ext(input logic [63:0] d, input logic [2:0] f3);
`ifdef WB_LOAD_EXTEND_EN
      case (f3)
         3'd0:    return 64'($signed(d[7:0]));
         3'd1:    return 64'($signed(d[15:0]));
         3'd2:    return 64'($signed(d[31:0]));
         3'd4:    return 64'(d[7:0]);
         3'd5:    return 64'(d[15:0]);
         3'd6:    return 64'(d[31:0]);
         default: return d;
      endcase
`else
      return (f3 == 3'd7) ? d : d;
`endif
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   // One cycle of the behavioural rules applied to the model queue.
   task automatic model_step(input bit av, input logic [4:0] ar, input logic [63:0] ad,
                             input bit lv, input logic [4:0] lr, input logic [63:0] ldd,
                             input logic [2:0] lf, input bit st);
      bit          push;
      ld_t         e;
      logic [63:0] v;
      push = lv && (mq.size() != LD_DEPTH);
      if (!st) begin
         if (av) begin
            if (ar != 0) begin
               exp_q.push_back({ar, ad});
               m_rf[ar] = ad;
               foreach (mq[i]) if (mq[i].rd == ar) mq[i].killed = 1'b1;
            end
            if (mq.size() != 0) m_starve++;
            else m_starve = 0;
         end else begin
            if (mq.size() != 0) begin
               e = mq.pop_front();
               if (!e.killed && e.rd != 0) begin
                  v = ld_ext(e.data, e.f3);
                  exp_q.push_back({e.rd, v});
                  m_rf[e.rd] = v;
               end
            end
            m_starve = 0;
         end
      end else begin
         if (av) m_err = 1'b1;
         if (mq.size() == 0) m_starve = 0;
      end
      if (push) mq.push_back('{lr, ldd, lf, 1'b0});
   endtask

   // ---------------- driver ----------------
   task automatic cycle(input bit av, input logic [4:0] ar, input logic [63:0] ad,
                        input bit lv, input logic [4:0] lr, input logic [63:0] ldd,
                        input logic [2:0] lf, input bit st);
      check("ld_ready", 64'(ld_ready_out), 64'(mq.size() != LD_DEPTH));
      check("bubble_req", 64'(bubble_req_out), 64'(m_starve >= STARVE_LIMIT));
      check("err", 64'(err_out), 64'(m_err));
      alu_valid_in    = av;
      alu_rd_in       = ar;
      alu_data_in     = ad;
      ld_valid_in     = lv;
      ld_rd_in        = lr;
      ld_data_in      = ldd;
      ld_funct3_in    = lf;
      stall_signal_in = st;
      model_step(av, ar, ad, lv, lr, ldd, lf, st);
      @(negedge clk_in);
      #1;
   endtask

   task automatic idle();
      cycle(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 3'd0, 1'b0);
   endtask

   // ---------------- monitor / scoreboard ----------------
   always @(negedge clk_in) begin
      if (rst_n_in && rd_write_signal_out) begin
         d_rf[rd_out] = wr_data_out;
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_write actual=x%0d:%h required=no write", rd_out, wr_data_out);
         end else begin
            logic [68:0] exp;
            exp = exp_q.pop_front();
            checks++;
            if ({rd_out, wr_data_out} !== exp) begin
               errors++;
               $display("FAIL write actual=x%0d:%h required=x%0d:%h",
                        rd_out, wr_data_out, exp[68:64], exp[63:0]);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [63:0] held_data;
      logic [4:0]  held_rd;
      bit          av;
      foreach (m_rf[i]) begin
         m_rf[i] = '0;
         d_rf[i] = '0;
      end

      // reset
      #1 rst_n_in = 1'b0;
      repeat (2) @(negedge clk_in);
      check("reset_we", 64'(rd_write_signal_out), 64'd0);
      check("reset_data", wr_data_out, 64'd0);
      check("reset_rd", 64'(rd_out), 64'd0);
      check("reset_ready", 64'(ld_ready_out), 64'd1);
      check("reset_bubble", 64'(bubble_req_out), 64'd0);
      check("reset_err", 64'(err_out), 64'd0);
      #1 rst_n_in = 1'b1;

      // ALU only: latency 1, single write
      cycle(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 3'd0, 1'b0);
      check("alu_we", 64'(rd_write_signal_out), 64'd1);
      check("alu_rd", 64'(rd_out), 64'd5);
      check("alu_data", wr_data_out, 64'h1234);
      idle();
      check("alu_we_drop", 64'(rd_write_signal_out), 64'd0);

      // LB load: written two edges after the push
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd7, 64'h80, 3'd0, 1'b0);
      check("ld_no_bypass", 64'(rd_write_signal_out), 64'd0);
      idle();
      check("lb_we", 64'(rd_write_signal_out), 64'd1);
`ifdef WB_LOAD_EXTEND_EN
      check("lb_data", wr_data_out, 64'hFFFF_FFFF_FFFF_FF80);
`else
      check("lb_data", wr_data_out, 64'h80);
`endif
      idle();

      // collision: younger ALU write to x9 kills the buffered load
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 64'h55, 3'd3, 1'b0);
      cycle(1'b1, 5'd9, 64'hAA, 1'b0, 5'd0, 64'd0, 3'd0, 1'b0);
      cycle(1'b1, 5'd3, 64'h33, 1'b0, 5'd0, 64'd0, 3'd0, 1'b0);
      idle();
      check("killed_no_write", 64'(rd_write_signal_out), 64'd0);
      idle();
      check("x9_after_kill", d_rf[9], 64'hAA);

      // full FIFO with ALU every cycle; starvation raises a bubble request
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 5'(10 + i), 64'(32'hA000 + i), i < 3, 5'(20 + i),
               64'(32'hB000 + i), 3'd3, 1'b0);
         if (i == 1) check("full_ready_low", 64'(ld_ready_out), 64'd0);
      end
      check("bubble_high", 64'(bubble_req_out), 64'd1);
      idle();
      check("bubble_cleared", 64'(bubble_req_out), 64'd0);
      check("head_popped_rd", 64'(rd_out), 64'd20);
      repeat (2) idle();

      // x0 suppression
      cycle(1'b1, 5'd0, 64'hDEAD, 1'b0, 5'd0, 64'd0, 3'd0, 1'b0);
      check("x0_we", 64'(rd_write_signal_out), 64'd0);
      check("x0_data", wr_data_out, 64'd0);

      // stall with ALU valid: dropped, error, outputs held
      cycle(1'b1, 5'd12, 64'hC0FFEE, 1'b0, 5'd0, 64'd0, 3'd0, 1'b0);
      held_data = 64'hC0FFEE;
      held_rd   = 5'd12;
      cycle(1'b1, 5'd13, 64'hBEEF, 1'b0, 5'd0, 64'd0, 3'd0, 1'b1);
      check("stall_we", 64'(rd_write_signal_out), 64'd0);
      check("stall_rd_hold", 64'(rd_out), 64'(held_rd));
      check("stall_data_hold", wr_data_out, held_data);
      check("stall_err", 64'(err_out), 64'd1);

      // reset mid-operation with two loads buffered
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd14, 64'h14, 3'd3, 1'b1);
      cycle(1'b0, 5'd0, 64'd0, 1'b1, 5'd15, 64'h15, 3'd3, 1'b1);
      check("buffered_full", 64'(ld_ready_out), 64'd0);
      ld_valid_in     = 1'b0;
      stall_signal_in = 1'b0;
      #2 rst_n_in = 1'b0;
      #1;
      check("midrst_ready", 64'(ld_ready_out), 64'd1);
      check("midrst_we", 64'(rd_write_signal_out), 64'd0);
      check("midrst_data", wr_data_out, 64'd0);
      check("midrst_rd", 64'(rd_out), 64'd0);
      check("midrst_err", 64'(err_out), 64'd0);
      mq.delete();
      m_starve = 0;
      m_err    = 1'b0;
      @(negedge clk_in);
      #1 rst_n_in = 1'b1;

      // random traffic
      for (int n = 0; n < 400; n++) begin
         av = ($urandom_range(0, 2) == 0) && (m_starve < STARVE_LIMIT);
         cycle(av, 5'($urandom_range(0, 7)), {$urandom(), $urandom()},
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
               {$urandom(), $urandom()}, 3'($urandom_range(0, 7)),
               $urandom_range(0, 9) == 0);
      end

      // drain and final state
      repeat (LD_DEPTH + 3) idle();
      check("drain_pending", 64'(exp_q.size()), 64'd0);
      for (int r = 0; r < 32; r++) check($sformatf("regfile_x%0d", r), d_rf[r], m_rf[r]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
